// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - fetch stage types; FAULT state exists only with JZJCOREF_FETCH_MISALIGN_CHECK_EN
package JZJCoreFTypes;

   localparam logic [31:0] PC_INCREMENT = 32'd4;

`ifdef JZJCOREF_FETCH_MISALIGN_CHECK_EN
   typedef enum logic [2:0] {REQUEST, WAIT, HOLD, DRAIN, FAULT} FetchState_t;
`else
   typedef enum logic [1:0] {REQUEST, WAIT, HOLD, DRAIN} FetchState_t;
`endif

endpackage

// File: rtl/fetch_unit_pc_register.sv
// rtl/fetch_unit_pc_register.sv - program counter with redirect load and +4 advance
module fetch_pc_register
   import JZJCoreFTypes::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h00000000
)
(
   input  logic        clock,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] load_value,
   input  logic        advance,
   output logic [31:0] pc
);

   // load wins over advance so a redirect always beats a same-cycle consume
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         pc <= RESET_VECTOR;
      else if (load)
         pc <= load_value;
      else if (advance)
         pc <= pc + PC_INCREMENT;
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM and output buffer; optional JZJCOREF_FETCH_MISALIGN_CHECK_EN fault detection
module fetch_unit
   import JZJCoreFTypes::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h00000000
)
(
   input  logic        clock,
   input  logic        reset,
   input  logic        redirect,
   input  logic [31:0] redirectTarget,
   output logic        memReqValid,
   input  logic        memReqReady,
   output logic [31:0] memReqAddress,
   input  logic        memRespValid,
   input  logic [31:0] memRespData,
   output logic        instructionValid,
   input  logic        instructionReady,
   output logic [31:0] instruction,
   output logic [31:0] pcOfInstruction
`ifdef JZJCOREF_FETCH_MISALIGN_CHECK_EN
   ,
   output logic        misalignedFetch
`endif
);

   FetchState_t state, state_next;
   logic [31:0] pc;
   logic [31:0] redirect_value;
   logic        capture;
   logic        consume;
   logic        instr_valid_q;
   logic [31:0] instr_q;
   logic [31:0] instr_pc_q;

`ifdef JZJCOREF_FETCH_MISALIGN_CHECK_EN
   logic misaligned;
   logic resp_pending, resp_pending_next;

   assign redirect_value  = redirectTarget;
   assign misaligned      = |redirectTarget[1:0];
   assign misalignedFetch = (state == FAULT);
`else
   assign redirect_value = redirectTarget & ~32'h3;
`endif

   fetch_pc_register #(
      .RESET_VECTOR(RESET_VECTOR)
   ) u_pc (
      .clock     (clock),
      .reset     (reset),
      .load      (redirect),
      .load_value(redirect_value),
      .advance   (consume),
      .pc        (pc)
   );

   assign memReqValid      = (state == REQUEST);
   assign memReqAddress    = pc;
   assign instructionValid = instr_valid_q;
   assign instruction      = instr_q;
   assign pcOfInstruction  = instr_pc_q;

   always_comb begin
      state_next = state;
      capture    = 1'b0;
      consume    = 1'b0;
`ifdef JZJCOREF_FETCH_MISALIGN_CHECK_EN
      resp_pending_next = resp_pending;
      if (memReqValid && memReqReady)
         resp_pending_next = 1'b1;
      else if (memRespValid)
         resp_pending_next = 1'b0;
`endif
      if (redirect) begin
         // a read accepted for the old path must still be drained before refetching
         case (state)
            REQUEST:     state_next = memReqReady ? DRAIN : REQUEST;
            WAIT, DRAIN: state_next = memRespValid ? REQUEST : DRAIN;
`ifdef JZJCOREF_FETCH_MISALIGN_CHECK_EN
            FAULT:       state_next = (resp_pending && !memRespValid) ? DRAIN : REQUEST;
`endif
            default:     state_next = REQUEST;
         endcase
`ifdef JZJCOREF_FETCH_MISALIGN_CHECK_EN
         if (misaligned)
            state_next = FAULT;
`endif
      end else begin
         case (state)
            REQUEST: if (memReqReady) state_next = WAIT;
            WAIT: begin
               if (memRespValid) begin
                  state_next = HOLD;
                  capture    = 1'b1;
               end
            end
            HOLD: begin
               if (instructionReady) begin
                  state_next = REQUEST;
                  consume    = 1'b1;
               end
            end
            DRAIN:   if (memRespValid) state_next = REQUEST;
            default: state_next = state;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= REQUEST;
         instr_valid_q <= 1'b0;
         instr_q       <= 32'h0;
         instr_pc_q    <= 32'h0;
`ifdef JZJCOREF_FETCH_MISALIGN_CHECK_EN
         resp_pending  <= 1'b0;
`endif
      end else begin
         state <= state_next;
`ifdef JZJCOREF_FETCH_MISALIGN_CHECK_EN
         resp_pending <= resp_pending_next;
`endif
         if (redirect) begin
            instr_valid_q <= 1'b0;
         end else if (capture) begin
            instr_valid_q <= 1'b1;
            instr_q       <= memRespData;
            instr_pc_q    <= pc;
         end else if (consume) begin
            instr_valid_q <= 1'b0;
         end
      end
   end

endmodule
